// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with a single-letter command decoder.
//
// Deserialises host-terminal bytes and checks their framing. A letter in
// {F,P,H,C,S,D} (either case) is held as the pending command. A following
// CR commits it as a one-cycle cmd_* pulse. Any unexpected byte raises cmd_err.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   uart_rx    asynchronous serial line, idle high
//   rx_byte    last correctly framed byte
//   rx_valid   1-cycle pulse when rx_byte updates
//   frame_err  1-cycle pulse when the stop bit is sampled low
//   cmd_feed   1-cycle pulse, committed 'F'/'f'
//   cmd_play   1-cycle pulse, committed 'P'/'p'
//   cmd_heal   1-cycle pulse, committed 'H'/'h'
//   cmd_clean  1-cycle pulse, committed 'C'/'c'
//   cmd_sleep  1-cycle pulse, committed 'S'/'s'
//   cmd_dump   1-cycle pulse, committed 'D'/'d'
//   cmd_err    1-cycle pulse on a malformed command sequence
//
// RX FSM states:
//   state   | meaning
//   IDLE    | line idle, waiting for rxs low
//   START   | timing to mid-start-bit, rejects glitches
//   DATA    | sampling 8 data bits, LSB first
//   STOP    | sampling stop bit
//   BREAK   | stop bit was low, waiting for line to return high

module uart_cmd_rx #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_feed,
    output logic       cmd_play,
    output logic       cmd_heal,
    output logic       cmd_clean,
    output logic       cmd_sleep,
    output logic       cmd_dump,
    output logic       cmd_err
);

    localparam int HALF_DELAY = DELAY_FRAMES / 2;
    localparam logic [15:0] FULL_TC = 16'(DELAY_FRAMES - 1);
    localparam logic [15:0] HALF_TC = 16'(HALF_DELAY - 1);

    if (DELAY_FRAMES < 4) begin : g_bad_delay
        $error("uart_cmd_rx: DELAY_FRAMES must be >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // Pending command codes; zero means nothing pending.
    localparam logic [2:0] P_NONE  = 3'd0;
    localparam logic [2:0] P_FEED  = 3'd1;
    localparam logic [2:0] P_PLAY  = 3'd2;
    localparam logic [2:0] P_HEAL  = 3'd3;
    localparam logic [2:0] P_CLEAN = 3'd4;
    localparam logic [2:0] P_SLEEP = 3'd5;
    localparam logic [2:0] P_DUMP  = 3'd6;

    logic        rx_meta;
    logic        rxs;
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [2:0]  pend;
    logic [2:0]  letter_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_TC) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_TC) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_TC) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Clearing bit 5 folds lower-case letters onto upper case.
    always_comb begin
        letter_code = P_NONE;
        case (rx_byte & 8'hDF)
            8'h46:   letter_code = P_FEED;
            8'h50:   letter_code = P_PLAY;
            8'h48:   letter_code = P_HEAL;
            8'h43:   letter_code = P_CLEAN;
            8'h53:   letter_code = P_SLEEP;
            8'h44:   letter_code = P_DUMP;
            default: letter_code = P_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= P_NONE;
            cmd_feed  <= 1'b0;
            cmd_play  <= 1'b0;
            cmd_heal  <= 1'b0;
            cmd_clean <= 1'b0;
            cmd_sleep <= 1'b0;
            cmd_dump  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_feed  <= 1'b0;
            cmd_play  <= 1'b0;
            cmd_heal  <= 1'b0;
            cmd_clean <= 1'b0;
            cmd_sleep <= 1'b0;
            cmd_dump  <= 1'b0;
            cmd_err   <= 1'b0;
            if (frame_err) begin
                pend <= P_NONE;
            end else if (rx_valid) begin
                if (rx_byte == 8'h0D) begin
                    cmd_feed  <= (pend == P_FEED);
                    cmd_play  <= (pend == P_PLAY);
                    cmd_heal  <= (pend == P_HEAL);
                    cmd_clean <= (pend == P_CLEAN);
                    cmd_sleep <= (pend == P_SLEEP);
                    cmd_dump  <= (pend == P_DUMP);
                    pend      <= P_NONE;
                end else if (rx_byte == 8'h0A) begin
                    pend <= pend;
                end else if (letter_code != P_NONE) begin
                    pend <= letter_code;
                end else begin
                    cmd_err <= 1'b1;
                    pend    <= P_NONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

    localparam int D = 8;

    localparam int K_RXV = 0;
    localparam int K_FE  = 1;
    localparam int K_CMD = 2;

    // cmd vector bit order: feed, play, heal, clean, sleep, dump, err
    localparam logic [6:0] C_FEED  = 7'b000_0001;
    localparam logic [6:0] C_PLAY  = 7'b000_0010;
    localparam logic [6:0] C_HEAL  = 7'b000_0100;
    localparam logic [6:0] C_CLEAN = 7'b000_1000;
    localparam logic [6:0] C_SLEEP = 7'b001_0000;
    localparam logic [6:0] C_DUMP  = 7'b010_0000;
    localparam logic [6:0] C_ERR   = 7'b100_0000;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_feed, cmd_play, cmd_heal, cmd_clean, cmd_sleep, cmd_dump, cmd_err;
    logic [6:0] cmd_vec;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_rxv_cyc = -10;

    uart_cmd_rx #(.DELAY_FRAMES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .cmd_feed  (cmd_feed),
        .cmd_play  (cmd_play),
        .cmd_heal  (cmd_heal),
        .cmd_clean (cmd_clean),
        .cmd_sleep (cmd_sleep),
        .cmd_dump  (cmd_dump),
        .cmd_err   (cmd_err)
    );

    assign cmd_vec = {cmd_err, cmd_dump, cmd_sleep, cmd_clean, cmd_heal, cmd_play, cmd_feed};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse pops the next expected event.
    always @(negedge clk) begin
        int  n;
        ev_t obs;
        ev_t e;
        if (!rst) begin
            n = int'(rx_valid) + int'(frame_err) + int'(cmd_vec != 7'd0);
            obs.kind = K_RXV;
            obs.data = 8'h00;
            if (rx_valid) begin
                obs.kind = K_RXV; obs.data = rx_byte;
            end else if (frame_err) begin
                obs.kind = K_FE;  obs.data = 8'h00;
            end else begin
                obs.kind = K_CMD; obs.data = {1'b0, cmd_vec};
            end
            if (n > 1) begin
                checks++;
                errors++;
                $display("FAIL multi_event: rxv=%0b fe=%0b cmd=%b, required at most one", rx_valid, frame_err, cmd_vec);
            end else if (n == 1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind=%0d data=%h at cycle %0d, required none", obs.kind, obs.data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs.kind != e.kind || obs.data != e.data) begin
                        errors++;
                        $display("FAIL event: got kind=%0d data=%h, required kind=%0d data=%h", obs.kind, obs.data, e.kind, e.data);
                    end
                    if (obs.kind == K_CMD) begin
                        checks++;
                        if (cyc != last_rxv_cyc + 1) begin
                            errors++;
                            $display("FAIL cmd_latency: cmd at cycle %0d, rx_valid at %0d, required 1 cycle apart", cyc, last_rxv_cyc);
                        end
                    end
                end
            end
            if (rx_valid) last_rxv_cyc = cyc;
        end
    end

    task automatic exp_rxv(input logic [7:0] b);
        ev_t e;
        e.kind = K_RXV; e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic exp_ev(input int k, input logic [6:0] m);
        ev_t e;
        e.kind = k; e.data = {1'b0, m};
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (D) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (D) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({rx_byte, rx_valid, frame_err, cmd_vec} != 17'd0) begin
            errors++;
            $display("FAIL %s: rx_byte=%h rxv=%0b fe=%0b cmd=%b, required all 0", name, rx_byte, rx_valid, frame_err, cmd_vec);
        end
    endtask

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 'F' then CR
        exp_rxv(8'h46); exp_rxv(8'h0D); exp_ev(K_CMD, C_FEED);
        send_byte(8'h46, 1'b1);
        repeat (3) @(negedge clk);
        send_byte(8'h0D, 1'b1);
        wait_drain("t1");

        // 2: "d", LF, CR back-to-back
        exp_rxv(8'h64); exp_rxv(8'h0A); exp_rxv(8'h0D); exp_ev(K_CMD, C_DUMP);
        send_byte(8'h64, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t2");

        // 3: short glitch, then 'S', CR
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        exp_rxv(8'h53); exp_rxv(8'h0D); exp_ev(K_CMD, C_SLEEP);
        send_byte(8'h53, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t3");

        // 4: 'H' with bad stop bit, then lone CR
        exp_ev(K_FE, 7'd0);
        send_byte(8'h48, 1'b0);
        repeat (10) @(negedge clk);
        wait_drain("t4a");
        checks++;
        if (rx_byte != 8'h0D) begin
            errors++;
            $display("FAIL rx_byte_hold: got %h, required 0d", rx_byte);
        end
        exp_rxv(8'h0D);
        send_byte(8'h0D, 1'b1);
        wait_drain("t4b");

        // 5: 'P', 'X', CR, 'C', CR
        exp_rxv(8'h50); exp_rxv(8'h58); exp_ev(K_CMD, C_ERR); exp_rxv(8'h0D);
        exp_rxv(8'h43); exp_rxv(8'h0D); exp_ev(K_CMD, C_CLEAN);
        send_byte(8'h50, 1'b1);
        send_byte(8'h58, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t5");

        // 6: reset at data bit 4 of 0xF0 (rest of frame is high), then 'F', CR
        uart_rx = 1'b0;
        repeat (5 * D) @(negedge clk);
        uart_rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_midframe");
        @(negedge clk);
        rst = 1'b0;
        repeat (5 * D) @(negedge clk);
        wait_drain("t6a");
        exp_rxv(8'h46); exp_rxv(8'h0D); exp_ev(K_CMD, C_FEED);
        send_byte(8'h46, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t6b");

        // lower-case heal and play plus a replaced pending letter
        exp_rxv(8'h68); exp_rxv(8'h70); exp_rxv(8'h0D); exp_ev(K_CMD, C_PLAY);
        send_byte(8'h68, 1'b1);
        send_byte(8'h70, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t7");

        exp_rxv(8'h48); exp_rxv(8'h0D); exp_ev(K_CMD, C_HEAL);
        send_byte(8'h48, 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_drain("t8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
